seg7_scan_display: RTL and testbench

- Downstream consumer of the memory-mapped digit register. Takes the 32-bit value held by the IO write stage and time-multiplexes it as 8 hex digits onto the board's 8-digit common-anode 7-segment display.
- Contains the scan divider, frame-coherent data snapshot, anti-ghost blanking and hex-to-segment decode.
- All outputs are registered.

---
 rtl/seg7_scan_display_pkg.sv | 35 +++
 rtl/seg7_if.sv | 12 +
 rtl/seg7_scan_display_hex_decode.sv | 33 +++
 rtl/seg7_scan_display.sv | 77 +++++++
 tb/tb_seg7_scan_display.sv | 137 +++++++++++++
 5 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the 8-digit 7-segment scan display: digit count,
// active-low segment codes ({a,b,c,d,e,f,g}) and the leading-zero mask helper.
package seg7_scan_display_pkg;

  localparam int         DIGIT_NUM = 8;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  // Bit i set when nibble i and every higher nibble are zero; digit 0 is never dark.
  function automatic logic [7:0] lz_mask(input logic [31:0] v);
    logic [7:0] m;
    m = '0;
    for (int i = 1; i < DIGIT_NUM; i++) begin
      if ((v >> (4 * i)) == 32'd0) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Display-side bundle: value to show plus the active-low digit/segment pins.
interface seg7_if;
  logic [31:0] data;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg;
  logic        led_dp;

  modport master (output data,
                  input  led_en, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp);
  modport slave  (input  data,
                  output led_en, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp);
endinterface

// File: rtl/seg7_scan_display_hex_decode.sv
// Combinational hex nibble to active-low {a..g} segment pattern.
module seg7_hex_decode
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Straight lookup table.
  always_comb begin
    seg_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// 8-digit common-anode scan driver: slot divider, per-frame snapshot of data,
// blank period at each slot start and registered digit/segment outputs.
// Optional macro SEG7_LEADING_ZERO_SUPPRESS_EN keeps leading zero digits dark.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int DIV_CNT      = 20000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic clk,
  input  logic rst_n,
  seg7_if.slave bus
);

  localparam int            CW       = $clog2(DIV_CNT);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CNT - 1);
  localparam logic [31:0]   BLANK_U  = 32'(BLANK_CYCLES);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    en_q, en_d;
  logic [6:0]    seg_q, seg_d;
  logic [6:0]    dec_seg;
  logic [3:0]    nib;
  logic [7:0]    dark_mask;
  logic          wrap, blank, dark;

  seg7_hex_decode u_dec (.nib_i(nib), .seg_o(dec_seg));

  // Next state; outputs are computed from next-state values so the registered
  // pins line up with the counter they were derived from.
  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + CW'(1);
    digit_d   = wrap ? digit_q + 3'd1 : digit_q;
    shadow_d  = (wrap && digit_q == 3'd7) ? bus.data : shadow_q;
    nib       = shadow_d[{digit_d, 2'b00} +: 4];
    blank     = (32'(div_cnt_d) < BLANK_U);
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
    dark_mask = lz_mask(shadow_d);
`else
    dark_mask = 8'h00;
`endif
    dark      = dark_mask[digit_d];
    en_d      = (blank || dark) ? 8'hFF : ~(8'b1 << digit_d);
    seg_d     = dark ? SEG_OFF : dec_seg;
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      digit_q   <= '0;
      shadow_q  <= '0;
      en_q      <= 8'hFF;
      seg_q     <= SEG_OFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      en_q      <= en_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.led_en = en_q;
  assign bus.led_ca = seg_q[6];
  assign bus.led_cb = seg_q[5];
  assign bus.led_cc = seg_q[4];
  assign bus.led_cd = seg_q[3];
  assign bus.led_ce = seg_q[2];
  assign bus.led_cf = seg_q[1];
  assign bus.led_cg = seg_q[0];
  assign bus.led_dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed phases plus random data/reset traffic,
// checked every cycle against a cycle-count based reference of the display.
module tb_seg7_scan_display;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

  logic clk;
  logic rst_n;
  seg7_if bus ();

  seg7_scan_display #(.DIV_CNT(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment table {a..g}, active-low, indexed by hex value.
  logic [6:0] HEX [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int          vectors;
  int          miscompares;
  int          k;          // edges since the last reset edge
  logic [31:0] shadow_m;   // value the current frame displays
  bit          rst_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_model();
    int          slot, div;
    logic [3:0]  nib;
    logic        dark;
    logic [7:0]  exp_en;
    logic [6:0]  exp_seg, obs_seg;
    slot = (k / DIV) % 8;
    div  = k % DIV;
    nib  = 4'((shadow_m >> (4 * slot)) & 32'hF);
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
    dark = (slot != 0) && ((shadow_m >> (4 * slot)) == 32'd0);
`else
    dark = 1'b0;
`endif
    exp_en  = (rst_last || div < BLANK || dark) ? 8'hFF : ~(8'b1 << slot);
    exp_seg = (rst_last || dark) ? 7'h7F : HEX[nib];
    obs_seg = {bus.led_ca, bus.led_cb, bus.led_cc, bus.led_cd, bus.led_ce, bus.led_cf, bus.led_cg};
    chk("led_en", 32'(bus.led_en), 32'(exp_en));
    chk("segs", 32'(obs_seg), 32'(exp_seg));
    chk("led_dp", 32'(bus.led_dp), 32'd1);
    chk("onehot_en", 32'($countones(~bus.led_en) <= 1), 32'd1);
  endtask

  // Apply one cycle of inputs, advance the reference, then sample after the edge.
  task automatic step(input logic [31:0] d, input logic r);
    bus.data = d;
    rst_n    = r;
    @(posedge clk);
    if (!r) begin
      k = 0; shadow_m = '0; rst_last = 1'b1;
    end else begin
      k++; rst_last = 1'b0;
      if (k % FRAME == 0) shadow_m = d;
    end
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] rd;
    vectors = 0; miscompares = 0; k = 0; shadow_m = '0; rst_last = 1'b1;
    rst_n = 1'b0; bus.data = 32'h12345678;

    // Reset held three cycles: everything dark, snapshot stays clear.
    for (int i = 0; i < 3; i++) step(32'h12345678, 1'b0);

    // Scan order: frame 1 shows zeros, frame 2 shows 89ABCDEF.
    for (int i = 0; i < 70; i++) begin
      step(32'h89ABCDEF, 1'b1);
      if (k == FRAME)     chk("slot0_blank", 32'(bus.led_en), 32'hFF);
      if (k == FRAME + 1) begin
        chk("slot0_en", 32'(bus.led_en), 32'hFE);
        chk("slot0_seg", 32'(dut.seg_q), 32'(7'b0111000));
      end
      if (k == FRAME + 29) begin
        chk("slot7_en", 32'(bus.led_en), 32'h7F);
        chk("slot7_seg", 32'(dut.seg_q), 32'(7'b0000000));
      end
      if (k == 2 * FRAME + 1) chk("period", 32'(bus.led_en), 32'hFE);
    end

    // Snapshot coherence: data flips during slot 3 of a zero frame.
    step(32'h0, 1'b0);
    for (int i = 0; i < FRAME + 3 * DIV + 1; i++) step(32'h0, 1'b1);
    for (int i = 0; i < 40; i++) step(32'hFFFFFFFF, 1'b1);

    // Decode sweep over all 16 codes.
    for (int i = 0; i < 2 * FRAME; i++) step(32'h76543210, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) step(32'hFEDCBA98, 1'b1);

    // Reset for one cycle during slot 5.
    for (int i = 0; i < 2 * FRAME && ((k / DIV) % 8) != 5; i++) step(32'hFEDCBA98, 1'b1);
    step(32'hFEDCBA98, 1'b0);
    chk("midreset_en", 32'(bus.led_en), 32'hFF);
    step(32'hFEDCBA98, 1'b1);
    chk("post_reset_digit0", 32'(bus.led_en), 32'hFE);
    chk("post_reset_zero", 32'(dut.seg_q), 32'(7'b0000001));
    for (int i = 0; i < 40; i++) step(32'hFEDCBA98, 1'b1);

    // Leading-zero cases (full display in the default build).
    for (int i = 0; i < 2 * FRAME + 4; i++) step(32'h00000A05, 1'b1);
    for (int i = 0; i < 2 * FRAME + 4; i++) step(32'h0, 1'b1);

    // Random traffic with sparse data changes and occasional resets.
    rd = $urandom;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) rd = $urandom;
      if ($urandom_range(0, 3) == 0) rd = rd & 32'h0000FFFF;
      step(rd, ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
